alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 25 ++
 rtl/alu_arbiter_alu.sv | 42 ++++
 rtl/alu_arbiter.sv | 106 ++++++++++
 tb/tb_alu_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU select encodings and helpers for alu_arbiter
package alu_arbiter_pkg;

    typedef enum int {
        ALU_ADD   = 0,
        ALU_SUB   = 1,
        ALU_AND   = 2,
        ALU_OR    = 3,
        ALU_XOR   = 4,
        ALU_SLT   = 5,
        ALU_SLTU  = 6,
        ALU_SLL   = 7,
        ALU_SRL   = 8,
        ALU_SRA   = 9,
        ALU_COPY1 = 10
    } alu_op_e;

    localparam int LAST_VALID_SEL = 10;

    // Codes above the last encoding produce a zero result and raise rsp_err.
    function automatic logic sel_undefined(input int sel);
        return sel > LAST_VALID_SEL;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU shared by both requesters
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] result
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] shamt;
    logic            lt_signed;
    logic            lt_unsigned;

    assign shamt       = op2[SH_W-1:0];
    assign lt_signed   = $signed(op1) < $signed(op2);
    assign lt_unsigned = op1 < op2;

    always_comb begin
        result = '0;
        case (int'(sel))
            ALU_ADD:   result = op1 + op2;
            ALU_SUB:   result = op1 - op2;
            ALU_AND:   result = op1 & op2;
            ALU_OR:    result = op1 | op2;
            ALU_XOR:   result = op1 ^ op2;
            ALU_SLT:   result = {{(DATA_W-1){1'b0}}, lt_signed};
            ALU_SLTU:  result = {{(DATA_W-1){1'b0}}, lt_unsigned};
            ALU_SLL:   result = op1 << shamt;
            ALU_SRL:   result = op1 >> shamt;
            ALU_SRA:   result = $signed(op1) >>> shamt;
            ALU_COPY1: result = op1;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter around one ALU with a registered response slot
// Define ALU_ARBITER_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_op1,
    input  logic [2*DATA_W-1:0]   req_op2,
    input  logic [2*SEL_W-1:0]    req_sel,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e              state;
    state_e              state_next;
    logic                owner;
    logic                grant;
    logic                slot_free;
    logic                accept;
    logic [DATA_W-1:0]   alu_op1;
    logic [DATA_W-1:0]   alu_op2;
    logic [SEL_W-1:0]    alu_sel;
    logic [DATA_W-1:0]   alu_result;

`ifdef ALU_ARBITER_RR_EN
    logic last;

    // On contention the requester that was not served last wins.
    always_comb begin
        grant = ~req_valid[0];
        if (&req_valid) begin
            grant = ~last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant;
        end
    end
`else
    assign grant = ~req_valid[0];
`endif

    assign slot_free = (state == S_IDLE) || rsp_ready[owner];
    assign accept    = !rst && slot_free && req_valid[grant];
    assign req_ready = {grant, ~grant} & {2{accept}};

    assign alu_op1 = grant ? req_op1[2*DATA_W-1:DATA_W] : req_op1[DATA_W-1:0];
    assign alu_op2 = grant ? req_op2[2*DATA_W-1:DATA_W] : req_op2[DATA_W-1:0];
    assign alu_sel = grant ? req_sel[2*SEL_W-1:SEL_W]   : req_sel[SEL_W-1:0];

    alu_arbiter_alu #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_alu (
        .op1    (alu_op1),
        .op2    (alu_op2),
        .sel    (alu_sel),
        .result (alu_result)
    );

    // A drain and a new accept in the same cycle keep the slot in HOLD with no bubble.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = S_HOLD;
        end else if (state == S_HOLD && rsp_ready[owner]) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner    <= grant;
                rsp_data <= alu_result;
                rsp_err  <= sel_undefined(int'(alu_sel));
            end
        end
    end

    assign rsp_valid = (state == S_HOLD) ? {owner, ~owner} : 2'b00;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural reference model
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [7:0]  req_sel;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int checks;
    int errors;

    // Reference model: one result slot with an owner, plus the last-served pointer.
    logic        m_hold;
    logic        m_owner;
    logic [31:0] m_data;
    logic        m_err;
    logic        m_ptr;

    alu_arbiter #(.DATA_W(32), .SEL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return $signed(a) >>> b[4:0];
            4'd10:   return a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] predict_ready();
        int winner;
        if (rst) return 2'b00;
        if (m_hold && !rsp_ready[m_owner]) return 2'b00;
        if (req_valid == 2'b00) return 2'b00;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARBITER_RR_EN
            winner = (m_ptr == 1'b0) ? 1 : 0;
`else
            winner = 0;
`endif
        end else begin
            winner = req_valid[1] ? 1 : 0;
        end
        return (winner == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] expect_valid();
        if (!m_hold) return 2'b00;
        return m_owner ? 2'b10 : 2'b01;
    endfunction

    // Advance one clock from a negedge, updating the model from the inputs seen at the edge.
    task automatic tick();
        logic [1:0] acc;
        int         n;
        acc = predict_ready();
        @(posedge clk);
        if (rst) begin
            m_hold  = 1'b0;
            m_owner = 1'b0;
            m_data  = 32'd0;
            m_err   = 1'b0;
            m_ptr   = 1'b1;
        end else if (acc != 2'b00) begin
            n       = acc[1] ? 1 : 0;
            m_data  = alu_model(req_sel[4*n +: 4], req_op1[32*n +: 32], req_op2[32*n +: 32]);
            m_err   = (req_sel[4*n +: 4] > 4'd10);
            m_owner = (n == 1);
            m_ptr   = (n == 1);
            m_hold  = 1'b1;
        end else if (m_hold && rsp_ready[m_owner]) begin
            m_hold = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_lane(input int n, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        req_op1[32*n +: 32] = a;
        req_op2[32*n +: 32] = b;
        req_sel[4*n +: 4]   = s;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_op1   = 64'd0;
        req_op2   = 64'd0;
        req_sel   = 8'd0;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b exp 00", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h e=%b exp v=00 d=0 e=0", rsp_valid, rsp_data, rsp_err);
        end
        rst       = 1'b0;
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_single();
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        set_lane(0, 32'd5, 32'd7, 4'd0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready got %b exp 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd12 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp got v=%b d=%0d e=%b exp v=01 d=12 e=0", rsp_valid, rsp_data, rsp_err);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0]  exp_ready;
        logic [31:0] exp_data;
        do_reset();
        set_lane(0, 32'd10, 32'd3, 4'd1);
        set_lane(1, 32'hF0, 32'h0F, 4'd4);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARBITER_RR_EN
            exp_ready = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp_data  = (i % 2 == 1) ? 32'hFF : 32'd7;
`else
            exp_ready = 2'b01;
            exp_data  = 32'd7;
`endif
            #1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL contend_ready[%0d] got %b exp %b", i, req_ready, exp_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== exp_ready || rsp_data !== exp_data) begin
                errors++;
                $display("FAIL contend_rsp[%0d] got v=%b d=%h exp v=%b d=%h", i, rsp_valid, rsp_data, exp_ready, exp_data);
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_lane(1, 32'h8000_0000, 32'd4, 4'd9);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_first_ready got %b exp 10", req_ready);
        end
        tick();
        set_lane(1, 32'd1, 32'd1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== 2'b00 || rsp_valid !== 2'b10 || rsp_data !== 32'hF800_0000) begin
                errors++;
                $display("FAIL bp_hold[%0d] got r=%b v=%b d=%h exp r=00 v=10 d=f8000000", i, req_ready, rsp_valid, rsp_data);
            end
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_release_ready got %b exp 10", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'd2) begin
            errors++;
            $display("FAIL bp_next_rsp got v=%b d=%h exp v=10 d=2", rsp_valid, rsp_data);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_undefined_sel();
        set_lane(0, $urandom, $urandom, 4'd13);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        tick();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd0 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL undef_rsp got v=%b d=%h e=%b exp v=01 d=0 e=1", rsp_valid, rsp_data, rsp_err);
        end
        set_lane(0, 32'hFFFF_FFFF, 32'd1, 4'd5);
        tick();
        checks++;
        if (rsp_data !== 32'd1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL slt_after_undef got d=%h e=%b exp d=1 e=0", rsp_data, rsp_err);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        set_lane(1, 32'd3, 32'd4, 4'd0);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        tick();
        checks++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'd7) begin
            errors++;
            $display("FAIL rmid_hold got v=%b d=%h exp v=10 d=7", rsp_valid, rsp_data);
        end
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rmid_ready_in_rst got %b exp 00", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'd0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rmid_after_rst got v=%b d=%h r=%b exp v=00 d=0 r=00", rsp_valid, rsp_data, req_ready);
        end
        rst = 1'b0;
        set_lane(0, 32'd100, 32'd23, 4'd0);
        rsp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rmid_first_grant got %b exp 01", req_ready);
        end
        tick();
    endtask

    task automatic test_non_owner_drain();
        rsp_ready = 2'b10;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL nonowner_ready got %b exp 00", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd123) begin
            errors++;
            $display("FAIL nonowner_retain got v=%b d=%0d exp v=01 d=123", rsp_valid, rsp_data);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        tick();
    endtask

    task automatic test_random();
        logic [1:0] exp_ready;
        logic [1:0] exp_valid;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            req_op1   = {$urandom, $urandom};
            req_op2   = {$urandom, $urandom};
            req_sel   = 8'($urandom);
            #1;
            exp_ready = predict_ready();
            exp_valid = expect_valid();
            checks++;
            if (req_ready !== exp_ready || rsp_valid !== exp_valid || rsp_data !== m_data || rsp_err !== m_err) begin
                errors++;
                $display("FAIL random[%0d] got r=%b v=%b d=%h e=%b exp r=%b v=%b d=%h e=%b",
                         i, req_ready, rsp_valid, rsp_data, rsp_err, exp_ready, exp_valid, m_data, m_err);
            end
            tick();
        end
        rst       = 1'b0;
        req_valid = 2'b00;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_hold  = 1'b0;
        m_owner = 1'b0;
        m_data  = 32'd0;
        m_err   = 1'b0;
        m_ptr   = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_undefined_sel();
        test_reset_mid();
        test_non_owner_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
